stride_decoder: RTL and testbench

// Consumes one conv-stride instruction (one output pixel position, all output channels) from instgen.

---
 rtl/stride_decoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_stride_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stride_decoder.sv
// Expands one conv-stride instruction into a stream of per-MAC operations
// (co, ci, ky, kx loop order) with incrementally computed BRAM addresses.
module stride_decoder #(
    parameter int FRAM_AW = 16,
    parameter int KRAM_AW = 16,
    parameter int DW      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAM_AW-1:0] stride_feature_baseaddr,
    input  logic [KRAM_AW-1:0] stride_kernel_baseaddr,
    input  logic [DW-1:0]      stride_feature_chin,
    input  logic [DW-1:0]      stride_feature_chout,
    input  logic [DW-1:0]      stride_feature_width,
    input  logic [DW-1:0]      stride_feature_height,
    input  logic [7:0]         stride_kernel_sizeh,
    input  logic [7:0]         stride_kernel_sizew,
    input  logic               stride_has_bias,
    input  logic               stride_has_relu,
    input  logic [FRAM_AW-1:0] stride_wb_baseaddr,
    input  logic [DW-1:0]      stride_wb_ch_offset,
    input  logic               inst_valid,
    output logic               decoder_ready,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [FRAM_AW-1:0] op_fram_addr,
    output logic [KRAM_AW-1:0] op_kram_addr,
    output logic               op_first,
    output logic               op_last,
    output logic               op_bias,
    output logic               op_relu,
    output logic [FRAM_AW-1:0] op_wb_addr,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2,
        S_BIAS  = 2'd3
    } state_t;

    localparam logic [DW-1:0]      D_ONE = 1;
    localparam logic [KRAM_AW-1:0] K_ONE = 1;

    state_t             state_q, state_d;
    logic [FRAM_AW-1:0] fbase_q, fbase_d;
    logic [KRAM_AW-1:0] kbase_q, kbase_d;
    logic [DW-1:0]      chin_q, chin_d;
    logic [DW-1:0]      chout_q, chout_d;
    logic [FRAM_AW-1:0] width_q, width_d;
    logic [FRAM_AW-1:0] height_q, height_d;
    logic [7:0]         kh_q, kh_d;
    logic [7:0]         kw_q, kw_d;
    logic               bias_q, bias_d;
    logic               relu_q, relu_d;
    logic [FRAM_AW-1:0] wbbase_q, wbbase_d;
    logic [FRAM_AW-1:0] wboff_q, wboff_d;
    logic [FRAM_AW-1:0] flat_q, flat_d;
    logic [DW-1:0]      co_q, co_d;
    logic [DW-1:0]      ci_q, ci_d;
    logic [7:0]         ky_q, ky_d;
    logic [7:0]         kx_q, kx_d;
    logic [FRAM_AW-1:0] f_ch_q, f_ch_d;
    logic [FRAM_AW-1:0] f_row_q, f_row_d;
    logic [KRAM_AW-1:0] k_mac_q, k_mac_d;
    logic [KRAM_AW-1:0] k_bias_q, k_bias_d;
    logic [FRAM_AW-1:0] wb_q, wb_d;

    logic               last_kx, last_ky, last_ci, last_co, mac_last, zero_dim;
    logic [KRAM_AW-1:0] ksz;

    // Only the low address-width bits of these fields matter (modulo arithmetic).
    logic unused_bits;
    assign unused_bits = ^{stride_feature_width, stride_feature_height, stride_wb_ch_offset};

    assign last_kx  = (kx_q == kw_q - 8'd1);
    assign last_ky  = (ky_q == kh_q - 8'd1);
    assign last_ci  = (ci_q == chin_q - D_ONE);
    assign last_co  = (co_q == chout_q - D_ONE);
    assign mac_last = last_kx & last_ky & last_ci;
    assign zero_dim = (chin_q == '0) | (chout_q == '0) | (kh_q == '0) | (kw_q == '0);
    assign ksz      = KRAM_AW'(kh_q) * KRAM_AW'(kw_q);

    always_comb begin
        state_d  = state_q;
        fbase_d  = fbase_q;
        kbase_d  = kbase_q;
        chin_d   = chin_q;
        chout_d  = chout_q;
        width_d  = width_q;
        height_d = height_q;
        kh_d     = kh_q;
        kw_d     = kw_q;
        bias_d   = bias_q;
        relu_d   = relu_q;
        wbbase_d = wbbase_q;
        wboff_d  = wboff_q;
        flat_d   = flat_q;
        co_d     = co_q;
        ci_d     = ci_q;
        ky_d     = ky_q;
        kx_d     = kx_q;
        f_ch_d   = f_ch_q;
        f_row_d  = f_row_q;
        k_mac_d  = k_mac_q;
        k_bias_d = k_bias_q;
        wb_d     = wb_q;

        unique case (state_q)
            S_IDLE: begin
                if (inst_valid) begin
                    state_d  = S_LOAD;
                    fbase_d  = stride_feature_baseaddr;
                    kbase_d  = stride_kernel_baseaddr;
                    chin_d   = stride_feature_chin;
                    chout_d  = stride_feature_chout;
                    width_d  = stride_feature_width[FRAM_AW-1:0];
                    height_d = stride_feature_height[FRAM_AW-1:0];
                    kh_d     = stride_kernel_sizeh;
                    kw_d     = stride_kernel_sizew;
                    bias_d   = stride_has_bias;
                    relu_d   = stride_has_relu;
                    wbbase_d = stride_wb_baseaddr;
                    wboff_d  = stride_wb_ch_offset[FRAM_AW-1:0];
                end
            end
            S_LOAD: begin
                flat_d   = width_q * height_q;
                // Bias words sit right after the whole chout*chin*ksz kernel block.
                k_bias_d = kbase_q + chout_q[KRAM_AW-1:0] * chin_q[KRAM_AW-1:0] * ksz;
                co_d     = '0;
                ci_d     = '0;
                ky_d     = '0;
                kx_d     = '0;
                f_ch_d   = fbase_q;
                f_row_d  = fbase_q;
                k_mac_d  = kbase_q;
                wb_d     = wbbase_q;
                state_d  = zero_dim ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                if (op_ready) begin
                    k_mac_d = k_mac_q + K_ONE;
                    if (!last_kx) begin
                        kx_d = kx_q + 8'd1;
                    end else begin
                        kx_d = '0;
                        if (!last_ky) begin
                            ky_d    = ky_q + 8'd1;
                            f_row_d = f_row_q + width_q;
                        end else begin
                            ky_d = '0;
                            if (!last_ci) begin
                                ci_d    = ci_q + D_ONE;
                                f_ch_d  = f_ch_q + flat_q;
                                f_row_d = f_ch_q + flat_q;
                            end else begin
                                ci_d    = '0;
                                f_ch_d  = fbase_q;
                                f_row_d = fbase_q;
                                if (bias_q) begin
                                    state_d = S_BIAS;
                                end else if (last_co) begin
                                    state_d = S_IDLE;
                                end else begin
                                    co_d = co_q + D_ONE;
                                    wb_d = wb_q + wboff_q;
                                end
                            end
                        end
                    end
                end
            end
            S_BIAS: begin
                if (op_ready) begin
                    k_bias_d = k_bias_q + K_ONE;
                    if (last_co) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ISSUE;
                        co_d    = co_q + D_ONE;
                        wb_d    = wb_q + wboff_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            fbase_q  <= '0;
            kbase_q  <= '0;
            chin_q   <= '0;
            chout_q  <= '0;
            width_q  <= '0;
            height_q <= '0;
            kh_q     <= '0;
            kw_q     <= '0;
            bias_q   <= 1'b0;
            relu_q   <= 1'b0;
            wbbase_q <= '0;
            wboff_q  <= '0;
            flat_q   <= '0;
            co_q     <= '0;
            ci_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            f_ch_q   <= '0;
            f_row_q  <= '0;
            k_mac_q  <= '0;
            k_bias_q <= '0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            fbase_q  <= fbase_d;
            kbase_q  <= kbase_d;
            chin_q   <= chin_d;
            chout_q  <= chout_d;
            width_q  <= width_d;
            height_q <= height_d;
            kh_q     <= kh_d;
            kw_q     <= kw_d;
            bias_q   <= bias_d;
            relu_q   <= relu_d;
            wbbase_q <= wbbase_d;
            wboff_q  <= wboff_d;
            flat_q   <= flat_d;
            co_q     <= co_d;
            ci_q     <= ci_d;
            ky_q     <= ky_d;
            kx_q     <= kx_d;
            f_ch_q   <= f_ch_d;
            f_row_q  <= f_row_d;
            k_mac_q  <= k_mac_d;
            k_bias_q <= k_bias_d;
            wb_q     <= wb_d;
        end
    end

    // All op fields come straight from registers, so they hold while stalled.
    assign decoder_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign op_valid      = (state_q == S_ISSUE) | (state_q == S_BIAS);
    assign op_bias       = (state_q == S_BIAS);
    assign op_first      = (state_q == S_ISSUE) & (ci_q == '0) & (ky_q == '0) & (kx_q == '0);
    assign op_last       = (state_q == S_BIAS) | ((state_q == S_ISSUE) & mac_last & ~bias_q);
    assign op_fram_addr  = f_row_q + FRAM_AW'(kx_q);
    assign op_kram_addr  = (state_q == S_BIAS) ? k_bias_q : k_mac_q;
    assign op_wb_addr    = wb_q;
    assign op_relu       = relu_q;

endmodule

// File: tb/tb_stride_decoder.sv
// Directed bench for stride_decoder: a loop-nest model queues every expected op,
// one negedge process compares each presented op and checks stall stability.
module tb_stride_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] stride_feature_baseaddr = '0;
    logic [15:0] stride_kernel_baseaddr = '0;
    logic [31:0] stride_feature_chin = '0;
    logic [31:0] stride_feature_chout = '0;
    logic [31:0] stride_feature_width = '0;
    logic [31:0] stride_feature_height = '0;
    logic [7:0]  stride_kernel_sizeh = '0;
    logic [7:0]  stride_kernel_sizew = '0;
    logic        stride_has_bias = 1'b0;
    logic        stride_has_relu = 1'b0;
    logic [15:0] stride_wb_baseaddr = '0;
    logic [31:0] stride_wb_ch_offset = '0;
    logic        inst_valid = 1'b0;
    logic        decoder_ready;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic [15:0] op_fram_addr;
    logic [15:0] op_kram_addr;
    logic        op_first, op_last, op_bias, op_relu;
    logic [15:0] op_wb_addr;
    logic        busy;

    stride_decoder #(.FRAM_AW(16), .KRAM_AW(16), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .stride_feature_baseaddr(stride_feature_baseaddr),
        .stride_kernel_baseaddr(stride_kernel_baseaddr),
        .stride_feature_chin(stride_feature_chin),
        .stride_feature_chout(stride_feature_chout),
        .stride_feature_width(stride_feature_width),
        .stride_feature_height(stride_feature_height),
        .stride_kernel_sizeh(stride_kernel_sizeh),
        .stride_kernel_sizew(stride_kernel_sizew),
        .stride_has_bias(stride_has_bias),
        .stride_has_relu(stride_has_relu),
        .stride_wb_baseaddr(stride_wb_baseaddr),
        .stride_wb_ch_offset(stride_wb_ch_offset),
        .inst_valid(inst_valid),
        .decoder_ready(decoder_ready),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_fram_addr(op_fram_addr),
        .op_kram_addr(op_kram_addr),
        .op_first(op_first),
        .op_last(op_last),
        .op_bias(op_bias),
        .op_relu(op_relu),
        .op_wb_addr(op_wb_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] fram;
        logic [15:0] kram;
        logic [15:0] wb;
        logic        first;
        logic        last;
        logic        bias;
        logic        relu;
    } op_t;

    op_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    bit          rand_ready = 1'b0;
    logic [15:0] bias_kram[$];
    logic [15:0] last_fram, last_kram, last_wb;
    logic        last_first, last_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Expected op stream straight from the address formulas.
    task automatic build(input int fb, input int kb, input int cin, input int cout,
                         input int w, input int h, input int kh, input int kw,
                         input bit hb, input bit hr, input int wbb, input int wbo);
        op_t o;
        if (cin == 0 || cout == 0 || kh == 0 || kw == 0) return;
        for (int co = 0; co < cout; co++) begin
            for (int ci = 0; ci < cin; ci++)
                for (int ky = 0; ky < kh; ky++)
                    for (int kx = 0; kx < kw; kx++) begin
                        o.fram  = 16'(fb + ci * w * h + ky * w + kx);
                        o.kram  = 16'(kb + ((co * cin + ci) * kh + ky) * kw + kx);
                        o.wb    = 16'(wbb + co * wbo);
                        o.first = (ci == 0 && ky == 0 && kx == 0);
                        o.last  = !hb && (ci == cin - 1 && ky == kh - 1 && kx == kw - 1);
                        o.bias  = 1'b0;
                        o.relu  = hr;
                        exp_q.push_back(o);
                    end
            if (hb) begin
                o.fram  = '0;
                o.kram  = 16'(kb + cout * cin * kh * kw + co);
                o.wb    = 16'(wbb + co * wbo);
                o.first = 1'b0;
                o.last  = 1'b1;
                o.bias  = 1'b1;
                o.relu  = hr;
                exp_q.push_back(o);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        op_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    op_t  e;
    op_t  prev;
    logic prev_valid;
    bit   prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if ({op_valid, op_fram_addr, op_kram_addr, op_wb_addr, op_first, op_last, op_bias, op_relu} !==
                    {prev_valid, prev.fram, prev.kram, prev.wb, prev.first, prev.last, prev.bias, prev.relu}) begin
                    errors++;
                    $display("FAIL stall_frozen: got v=%b fram=%0d kram=%0d wb=%0d, expected v=%b fram=%0d kram=%0d wb=%0d",
                             op_valid, op_fram_addr, op_kram_addr, op_wb_addr, prev_valid, prev.fram, prev.kram, prev.wb);
                end
            end
            if (op_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_op: got op_valid=1 kram=%0d, expected no op", op_kram_addr);
                end else begin
                    e = exp_q[0];
                    if (op_kram_addr !== e.kram || (!e.bias && op_fram_addr !== e.fram) || op_wb_addr !== e.wb ||
                        op_first !== e.first || op_last !== e.last || op_bias !== e.bias || op_relu !== e.relu) begin
                        errors++;
                        $display("FAIL op_%0d: got fram=%0d kram=%0d wb=%0d flbr=%b%b%b%b, expected fram=%0d kram=%0d wb=%0d flbr=%b%b%b%b",
                                 acc_cnt, op_fram_addr, op_kram_addr, op_wb_addr, op_first, op_last, op_bias, op_relu,
                                 e.fram, e.kram, e.wb, e.first, e.last, e.bias, e.relu);
                    end
                    if (op_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                        last_fram  = op_fram_addr;
                        last_kram  = op_kram_addr;
                        last_wb    = op_wb_addr;
                        last_first = op_first;
                        last_last  = op_last;
                        if (e.bias) bias_kram.push_back(op_kram_addr);
                    end
                end
            end
            prev_stall = op_valid && !op_ready;
            prev_valid = op_valid;
            prev.fram  = op_fram_addr;
            prev.kram  = op_kram_addr;
            prev.wb    = op_wb_addr;
            prev.first = op_first;
            prev.last  = op_last;
            prev.bias  = op_bias;
            prev.relu  = op_relu;
        end
    end

    task automatic drive(input int fb, input int kb, input int cin, input int cout,
                         input int w, input int h, input int kh, input int kw,
                         input bit hb, input bit hr, input int wbb, input int wbo);
        stride_feature_baseaddr = 16'(fb);
        stride_kernel_baseaddr  = 16'(kb);
        stride_feature_chin     = cin;
        stride_feature_chout    = cout;
        stride_feature_width    = w;
        stride_feature_height   = h;
        stride_kernel_sizeh     = 8'(kh);
        stride_kernel_sizew     = 8'(kw);
        stride_has_bias         = hb;
        stride_has_relu         = hr;
        stride_wb_baseaddr      = 16'(wbb);
        stride_wb_ch_offset     = wbo;
    endtask

    task automatic issue(input int fb, input int kb, input int cin, input int cout,
                         input int w, input int h, input int kh, input int kw,
                         input bit hb, input bit hr, input int wbb, input int wbo,
                         input bit rnd, output int cyc);
        bit zero;
        bit done;
        zero = (cin == 0 || cout == 0 || kh == 0 || kw == 0);
        done = 1'b0;
        rand_ready = rnd;
        acc_cnt = 0;
        bias_kram.delete();
        build(fb, kb, cin, cout, w, h, kh, kw, hb, hr, wbb, wbo);
        @(negedge clk);
        check("ready_before_issue", decoder_ready, 1);
        drive(fb, kb, cin, cout, w, h, kh, kw, hb, hr, wbb, wbo);
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        drive(16'hFFFF, 16'hFFFF, 0, 0, 99, 99, 0, 0, 1'b0, 1'b0, 16'hFFFF, 77);
        @(negedge clk);
        check("load_busy", busy, 1);
        check("load_no_op", op_valid, 0);
        @(negedge clk);
        if (zero) begin
            check("zero_ready_T2", decoder_ready, 1);
            check("zero_no_op", op_valid, 0);
        end else begin
            check("first_op_T2", op_valid, 1);
        end
        cyc = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #2;
            if (decoder_ready && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            cyc++;
        end
        check("done_in_time", done, 1);
        if (!done) exp_q.delete();
    endtask

    initial begin
        int  cyc;
        bit  hit;
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit hit;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", decoder_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ops", {op_valid, op_first, op_last, op_bias, op_relu}, 0);
        check("rst_addrs", {op_fram_addr, op_kram_addr}, 0);
        check("rst_wb", op_wb_addr, 0);
        rst_n = 1'b1;

        // 1x1 kernel, single op
        issue(7, 3, 1, 1, 4, 4, 1, 1, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        check("s1_count", acc_cnt, 1);
        check("s1_fram", last_fram, 7);
        check("s1_kram", last_kram, 3);
        check("s1_first", last_first, 1);
        check("s1_last", last_last, 1);
        check("s1_idle_T3", cyc, 0);

        // 3x3 kernel, 2 in / 2 out channels
        issue(10, 0, 2, 2, 5, 5, 3, 3, 1'b0, 1'b0, 100, 9, 1'b0, cyc);
        check("s2_count", acc_cnt, 36);
        check("s2_last_fram", last_fram, 47);
        check("s2_last_kram", last_kram, 35);
        check("s2_last_wb", last_wb, 109);
        check("s2_last_flag", last_last, 1);

        // same with bias and relu
        issue(10, 0, 2, 2, 5, 5, 3, 3, 1'b1, 1'b1, 100, 9, 1'b0, cyc);
        check("s3_count", acc_cnt, 38);
        check("s3_bias_ops", bias_kram.size(), 2);
        if (bias_kram.size() == 2) begin
            check("s3_bias0_kram", bias_kram[0], 36);
            check("s3_bias1_kram", bias_kram[1], 37);
        end

        // scenario 2 under random back-pressure
        issue(10, 0, 2, 2, 5, 5, 3, 3, 1'b0, 1'b0, 100, 9, 1'b1, cyc);
        check("s4_count", acc_cnt, 36);
        check("s4_last_fram", last_fram, 47);
        check("s4_last_wb", last_wb, 109);

        // chout = 0: accepted, nothing emitted
        issue(10, 0, 2, 0, 5, 5, 3, 3, 1'b0, 1'b0, 100, 9, 1'b0, cyc);
        check("s5_count", acc_cnt, 0);

        // reset while op 5 is presented
        rand_ready = 1'b0;
        acc_cnt = 0;
        build(10, 0, 2, 2, 5, 5, 3, 3, 1'b0, 1'b1, 100, 9);
        @(negedge clk);
        drive(10, 0, 2, 2, 5, 5, 3, 3, 1'b0, 1'b1, 100, 9);
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #2;
            if (acc_cnt >= 4) begin
                hit = 1'b1;
                break;
            end
        end
        check("s6_reached_op5", hit, 1);
        check("s6_op5_valid", op_valid, 1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_ops", {op_valid, op_first, op_last, op_bias, op_relu}, 0);
        check("s6_rst_addrs", {op_fram_addr, op_kram_addr}, 0);
        check("s6_rst_wb", op_wb_addr, 0);
        check("s6_rst_ready", {decoder_ready, busy}, 2'b10);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // fresh instruction after the abort starts from zero
        issue(10, 0, 2, 2, 5, 5, 3, 3, 1'b0, 1'b0, 100, 9, 1'b0, cyc);
        check("s7_count", acc_cnt, 36);
        check("s7_last_kram", last_kram, 35);
        check("s7_last_fram", last_fram, 47);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
